pixel_sort_param: RTL

Parametrised, fully pipelined pixel sorter; successor to the fixed 8×16-bit ascending sorter. Sorts NUM pixels of WIDTH bits per transaction through an odd-even transposition network, one registered stage per compare-exchange layer. Sort direction is selectable per transaction, a global stall freezes the pipeline, and the sort is stable. It sits between the window/line-buffer gather logic and the rank-select and median consumers in the pixel path.

---
 rtl/pixel_sort_pkg.sv | 24 ++
 rtl/pixel_sort_cmpx.sv | 52 +++++
 rtl/pixel_sort_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pixel_sort_pkg.sv
// pixel_sort_pkg
//   Shared definitions for the pixel sorter:
//     - SORT_ASC / SORT_DESC : mode encoding (lane 0 = min / max)
//     - EVEN/ODD_STAGE_FIRST : first lower lane compared in even/odd stages
//     - lane_lo()            : low bit of lane i inside a packed NUM*WIDTH bus
//     - stage_first_lane()   : lower lane of the first pair in stage s
//   Optional feature macro used by the other files: PIXEL_SORT_INDEX_EN.
package pixel_sort_pkg;

    localparam logic SORT_ASC  = 1'b0;
    localparam logic SORT_DESC = 1'b1;

    localparam int EVEN_STAGE_FIRST = 0;
    localparam int ODD_STAGE_FIRST  = 1;

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic int stage_first_lane(input int stage);
        return ((stage % 2) == 0) ? EVEN_STAGE_FIRST : ODD_STAGE_FIRST;
    endfunction

endpackage

// File: rtl/pixel_sort_cmpx.sv
// pixel_sort_cmpx
//   Combinational compare-exchange of one adjacent lane pair.
//   Ascending swaps only when lo > hi, descending only when lo < hi, so
//   equal values keep their order and the network stays stable.
//   Ports:
//     mode               0 = ascending, 1 = descending
//     lo_in / hi_in      values on the lower / upper lane
//     lo_out / hi_out    exchanged values
//     lo_tag_*/hi_tag_*  lane tags swapped with the values
//                        (present only with PIXEL_SORT_INDEX_EN)
module pixel_sort_cmpx
    import pixel_sort_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef PIXEL_SORT_INDEX_EN
    ,
    parameter int TW = 3
`endif
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] hi_in,
`ifdef PIXEL_SORT_INDEX_EN
    input  logic [TW-1:0]    lo_tag_in,
    input  logic [TW-1:0]    hi_tag_in,
    output logic [TW-1:0]    lo_tag_out,
    output logic [TW-1:0]    hi_tag_out,
`endif
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    logic swap;

    always_comb begin
        swap = 1'b0;
        if (mode == SORT_ASC) begin
            swap = (lo_in > hi_in);
        end else begin
            swap = (lo_in < hi_in);
        end
    end

    assign lo_out = swap ? hi_in : lo_in;
    assign hi_out = swap ? lo_in : hi_in;

`ifdef PIXEL_SORT_INDEX_EN
    assign lo_tag_out = swap ? hi_tag_in : lo_tag_in;
    assign hi_tag_out = swap ? lo_tag_in : hi_tag_in;
`endif

endmodule

// File: rtl/pixel_sort_param.sv
// pixel_sort_param
//   Fully pipelined odd-even transposition sorter: NUM registered stages,
//   one compare-exchange layer per stage. Mode and valid travel with each
//   transaction; stall freezes every register; reset is async active-low.
//   Optional feature macro: PIXEL_SORT_INDEX_EN (adds lane tags + index_out).
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous reset, asserted low
//     enable     transaction valid, captured when stall = 0
//     stall      hold all pipeline registers
//     mode       0 = ascending, 1 = descending
//     pixel_in   NUM lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//     pixel_out  sorted lanes (last stage register)
//     valid_out  pixel_out holds a completed transaction
//     mode_out   mode of the transaction on pixel_out
//     index_out  original lane of each output lane (PIXEL_SORT_INDEX_EN)
module pixel_sort_param
    import pixel_sort_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NUM   = 8
`ifdef PIXEL_SORT_INDEX_EN
    ,
    localparam int IDXW = $clog2(NUM)
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 stall,
    input  logic                 mode,
    input  logic [NUM*WIDTH-1:0] pixel_in,
    output logic [NUM*WIDTH-1:0] pixel_out,
    output logic                 valid_out,
    output logic                 mode_out
`ifdef PIXEL_SORT_INDEX_EN
    ,
    output logic [NUM*IDXW-1:0]  index_out
`endif
);

    // src_d[s] feeds the compare layer of stage s, net_d[s] is its result,
    // data_q[s] is the stage register.
    logic [NUM-1:0][WIDTH-1:0] src_d  [NUM];
    logic [NUM-1:0][WIDTH-1:0] net_d  [NUM];
    logic [NUM-1:0][WIDTH-1:0] data_q [NUM];
    logic [NUM-1:0]            mode_q;
    logic [NUM-1:0]            valid_q;
    logic [NUM-1:0]            mode_src;

`ifdef PIXEL_SORT_INDEX_EN
    logic [NUM-1:0][IDXW-1:0]  tag_src [NUM];
    logic [NUM-1:0][IDXW-1:0]  tag_net [NUM];
    logic [NUM-1:0][IDXW-1:0]  tag_q   [NUM];
`endif

    // Stage s compares with the mode that came into it: the raw input for
    // stage 0, the previous stage's registered mode otherwise.
    assign mode_src = {mode_q[NUM-2:0], mode};

    for (genvar s = 0; s < NUM; s++) begin : g_stage
        localparam int FIRST = stage_first_lane(s);

        if (s == 0) begin : g_first
            for (genvar i = 0; i < NUM; i++) begin : g_in
                assign src_d[0][i] = pixel_in[lane_lo(i, WIDTH) +: WIDTH];
`ifdef PIXEL_SORT_INDEX_EN
                assign tag_src[0][i] = IDXW'(i);
`endif
            end
        end else begin : g_chain
            assign src_d[s] = data_q[s-1];
`ifdef PIXEL_SORT_INDEX_EN
            assign tag_src[s] = tag_q[s-1];
`endif
        end

        for (genvar j = 0; j < NUM; j++) begin : g_lane
            if ((j >= FIRST) && (((j - FIRST) % 2) == 0) && ((j + 1) < NUM)) begin : g_pair
                pixel_sort_cmpx #(
                    .WIDTH (WIDTH)
`ifdef PIXEL_SORT_INDEX_EN
                    ,
                    .TW    (IDXW)
`endif
                ) u_cmpx (
                    .mode       (mode_src[s]),
                    .lo_in      (src_d[s][j]),
                    .hi_in      (src_d[s][j+1]),
`ifdef PIXEL_SORT_INDEX_EN
                    .lo_tag_in  (tag_src[s][j]),
                    .hi_tag_in  (tag_src[s][j+1]),
                    .lo_tag_out (tag_net[s][j]),
                    .hi_tag_out (tag_net[s][j+1]),
`endif
                    .lo_out     (net_d[s][j]),
                    .hi_out     (net_d[s][j+1])
                );
            end else if ((j < FIRST) || ((((j - FIRST) % 2) == 0) && ((j + 1) >= NUM))) begin : g_pass
                // Unpaired edge lane of this layer.
                assign net_d[s][j] = src_d[s][j];
`ifdef PIXEL_SORT_INDEX_EN
                assign tag_net[s][j] = tag_src[s][j];
`endif
            end
        end
    end

    // Bubbles still load data; only their valid bit marks them as empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            mode_q  <= '0;
            for (int s = 0; s < NUM; s++) begin
                data_q[s] <= '0;
`ifdef PIXEL_SORT_INDEX_EN
                tag_q[s]  <= '0;
`endif
            end
        end else if (!stall) begin
            valid_q <= {valid_q[NUM-2:0], enable};
            mode_q  <= mode_src;
            for (int s = 0; s < NUM; s++) begin
                data_q[s] <= net_d[s];
`ifdef PIXEL_SORT_INDEX_EN
                tag_q[s]  <= tag_net[s];
`endif
            end
        end
    end

    assign pixel_out = data_q[NUM-1];
    assign valid_out = valid_q[NUM-1];
    assign mode_out  = mode_q[NUM-1];

`ifdef PIXEL_SORT_INDEX_EN
    assign index_out = tag_q[NUM-1];
`endif

endmodule
